div66_by_33: RTL and testbench
==============================

DIV66_BY_33 -- requirements
Module: div66_by_33

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  request; sampled on rising clk edge.
REQ-005 dividend  input  66  unsigned dividend; sampled only when start is accepted.
REQ-006 divisor  input  33  unsigned divisor; sampled only when start is accepted.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 quotient  output  33  unsigned quotient, registered.
REQ-010 remainder  output  33  unsigned remainder, registered.
REQ-011 dbz  output  1  divide-by-zero flag, valid with done.
REQ-012 ovf  output  1  quotient-overflow flag, valid with done.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN, FIN.
REQ-014 SHALL accept start only in IDLE or FIN; in RUN, start SHALL be ignored and operands SHALL NOT be resampled.
REQ-015 On acceptance at edge k, SHALL capture the operands, clear dbz/ovf, set busy, and enter RUN.
REQ-016 SHALL use restoring radix-2 division.
REQ-017 The partial remainder SHALL be 34 bits and SHALL initialise to dividend[65:33].
REQ-018 On each RUN edge, SHALL shift in one dividend bit (bit 32 down to bit 0), subtract the divisor when the result is non-negative, and shift one quotient bit in at the LSB.
REQ-019 There SHALL be exactly 33 RUN iterations, at edges k+1..k+33.
REQ-020 At edge k+33, SHALL register quotient/remainder, clear busy, set done, and enter FIN.
REQ-021 done SHALL be high for exactly the one cycle following edge k+33.
REQ-022 FIN SHALL return to IDLE after one cycle unless start is high, in which case a new division SHALL be accepted (back-to-back, no bubble).
REQ-023 quotient/remainder SHALL hold their last values until the next done.
REQ-024 For divisor == 0: done SHALL assert after edge k+1 with dbz=1, quotient=33'h1_FFFF_FFFF, remainder=dividend[32:0]; no RUN iterations.
REQ-025 Correct results SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor.
REQ-026 dbz SHALL take priority over ovf.

Reset
REQ-027 While reset is low, SHALL force state=IDLE and busy=0, done=0, dbz=0, ovf=0, quotient=0, remainder=0, asynchronously.
REQ-028 Reset asserted mid-RUN SHALL abort the division with no done pulse.
REQ-029 After reset deasserts, the first start SHALL be accepted normally.

Configuration
REQ-030 With macro DIV66_BY_33_OVF_DETECT_EN defined, an accepted operation with divisor != 0 and dividend[65:33] >= divisor SHALL complete after edge k+1 with ovf=1, quotient=33'h1_FFFF_FFFF, remainder=0.
REQ-031 Without DIV66_BY_33_OVF_DETECT_EN, ovf SHALL be tied 0, no overflow comparator SHALL be built, and results for overflowing operands are unspecified (timing still 33 iterations).

Verification
REQ-032 dividend=66'd1000, divisor=33'd7, start at edge k -> done in the cycle after edge k+33, quotient=142, remainder=6, dbz=0, ovf=0.
REQ-033 dividend=(2^33-1)^2, divisor=2^33-1 -> quotient=33'h1_FFFF_FFFF, remainder=0, done after k+33.
REQ-034 divisor=0, dividend=66'h3_0000_0000_1234_5678 -> done after k+1, dbz=1, quotient=33'h1_FFFF_FFFF, remainder=33'h0_1234_5678.
REQ-035 Macro defined: dividend=2^40, divisor=1 -> done after k+1, ovf=1, quotient=all ones, remainder=0; macro undefined -> ovf=0, done after k+33.
REQ-036 Start pulsed at k+5 during RUN with other operands -> ignored, first result unchanged; start held high during the done cycle -> second division accepted, its done 34 cycles later.
REQ-037 reset driven low at k+10 during RUN -> all outputs 0 immediately, no done pulse; after release, 1000/7 completes correctly.

Source files
------------

// File: rtl/div66_by_33.sv
// 66/33-bit unsigned restoring divider, 33 iterations per operation.
// Optional overflow early-out: define DIV66_BY_33_OVF_DETECT_EN.
module div66_by_33 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [65:0] dividend,
  input  logic [32:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [32:0] quotient,
  output logic [32:0] remainder,
  output logic        dbz,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic [33:0] prem;
  logic [32:0] dvd_lo;
  logic [32:0] dvs;
  logic [32:0] qsh;
  logic        sp_dbz;
  logic        sp_ovf;
  logic        accept;
  logic        last;
  logic        ge;
  logic [33:0] shifted;
  logic [33:0] sub;
  logic [33:0] prem_nx;
  logic        ovf_hit;

`ifdef DIV66_BY_33_OVF_DETECT_EN
  assign ovf_hit = (divisor != 33'd0) && (dividend[65:33] >= divisor);
`else
  assign ovf_hit = 1'b0;
`endif

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) &&
                  (sp_dbz || sp_ovf || (cnt == 6'd32));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIN;
      FIN:     state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // One restoring step: shift in next dividend bit, trial subtract
  always_comb begin
    shifted = {prem[32:0], dvd_lo[32]};
    sub     = shifted - {1'b0, dvs};
    ge      = (shifted >= {1'b0, dvs});
    prem_nx = ge ? sub : shifted;
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      prem      <= '0;
      dvd_lo    <= '0;
      dvs       <= '0;
      qsh       <= '0;
      sp_dbz    <= 1'b0;
      sp_ovf    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          cnt    <= '0;
          prem   <= {1'b0, dividend[65:33]};
          dvd_lo <= dividend[32:0];
          dvs    <= divisor;
          qsh    <= '0;
          sp_dbz <= (divisor == 33'd0);
          sp_ovf <= ovf_hit;
          dbz    <= 1'b0;
        end
        (state == RUN): begin
          cnt    <= cnt + 6'd1;
          prem   <= prem_nx;
          dvd_lo <= {dvd_lo[31:0], 1'b0};
          qsh    <= {qsh[31:0], ge};
          if (sp_dbz) begin
            quotient  <= '1;
            remainder <= dvd_lo;
            dbz       <= 1'b1;
          end else if (sp_ovf) begin
            quotient  <= '1;
            remainder <= '0;
          end else if (cnt == 6'd32) begin
            quotient  <= {qsh[31:0], ge};
            remainder <= prem_nx[32:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV66_BY_33_OVF_DETECT_EN
  // Overflow flag, raised on the early-out completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          ovf <= 1'b0;
    else if (accept)                     ovf <= 1'b0;
    else if (state == RUN && sp_ovf &&
             !sp_dbz)                    ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_div66_by_33.sv
// Directed bench for div66_by_33.
// Expected results hand-computed per vector.
module tb_div66_by_33;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [65:0] dividend = '0;
  logic [32:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [32:0] quotient;
  logic [32:0] remainder;
  logic        dbz;
  logic        ovf;

  int total = 0;
  int bad = 0;
  int lat;
  int lat2;
  logic saw;

  always #5 clk = ~clk;

  div66_by_33 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  task automatic chk(input string tag,
                     input logic [65:0] got,
                     input logic [65:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands for one edge, then scramble them
  task automatic launch(input logic [65:0] a,
                        input logic [32:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = '1;
    divisor = 33'h5A5A;
  endtask

  // Edges until done is seen; -1 if it never comes
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    if (!done) n = -1;
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b1;

    // 1000 / 7
    launch(66'd1000, 33'd7);
    chk("b_busy", busy, 1);
    wait_done(lat);
    chk("b_lat", lat, 33);
    chk("b_q", quotient, 142);
    chk("b_r", remainder, 6);
    chk("b_dbz", dbz, 0);
    chk("b_ovf", ovf, 0);
    chk("b_busy0", busy, 0);
    @(posedge clk); #1;
    chk("b_pulse", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", quotient, 142);
    chk("hold_r", remainder, 6);

    // (2^33-1)^2 / (2^33-1)
    launch(66'h3_FFFF_FFFC_0000_0001, 33'h1_FFFF_FFFF);
    wait_done(lat);
    chk("m_lat", lat, 33);
    chk("m_q", quotient, 33'h1_FFFF_FFFF);
    chk("m_r", remainder, 0);

    // divide by zero
    launch(66'h3_0000_0000_1234_5678, 33'd0);
    wait_done(lat);
    chk("z_lat", lat, 1);
    chk("z_dbz", dbz, 1);
    chk("z_q", quotient, 33'h1_FFFF_FFFF);
    chk("z_r", remainder, 33'h0_1234_5678);
    chk("z_ovf", ovf, 0);

    // 2^40 / 1 overflows the quotient
    launch(66'd1 << 40, 33'd1);
    chk("o_dbz_clr", dbz, 0);
    wait_done(lat);
`ifdef DIV66_BY_33_OVF_DETECT_EN
    chk("o_lat", lat, 1);
    chk("o_ovf", ovf, 1);
    chk("o_q", quotient, 33'h1_FFFF_FFFF);
    chk("o_r", remainder, 0);
`else
    chk("o_lat", lat, 33);
    chk("o_ovf", ovf, 0);
`endif
    chk("o_dbz", dbz, 0);

    // start during RUN ignored, start in FIN accepted
    launch(66'd1000, 33'd7);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 66'd500;
    divisor = 33'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("i_lat", lat, 28);
    chk("i_q", quotient, 142);
    chk("i_r", remainder, 6);
    start = 1'b1;
    dividend = 66'd100;
    divisor = 33'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bb_busy", busy, 1);
    chk("bb_done", done, 0);
    wait_done(lat2);
    chk("bb_lat", lat2 + 1, 34);
    chk("bb_q", quotient, 11);
    chk("bb_r", remainder, 1);

    // reset in the middle of RUN
    launch(66'd1000, 33'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_q", quotient, 0);
    chk("ar_r", remainder, 0);
    chk("ar_dbz", dbz, 0);
    chk("ar_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw = saw | done;
    end
    chk("ar_nodone", saw, 0);
    launch(66'd1000, 33'd7);
    wait_done(lat);
    chk("ar2_lat", lat, 33);
    chk("ar2_q", quotient, 142);
    chk("ar2_r", remainder, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
